// File: rtl/up_down_mod_counter_pkg.sv
// Shared encodings and helpers for the up/down modulo counter family.
// Mode and direction codes are also exported as macros for non-SV users.
`ifndef COUNTER_DEFS_VH
`define COUNTER_DEFS_VH
`define CNT_MODE_WRAP 1'b0
`define CNT_MODE_SAT  1'b1
`define CNT_DIR_UP    1'b1
`define CNT_DIR_DOWN  1'b0
`endif

package up_down_mod_counter_pkg;

    typedef enum logic {
        CNT_DIR_DOWN = 1'b0,
        CNT_DIR_UP   = 1'b1
    } cnt_dir_e;

    typedef enum logic {
        CNT_MODE_WRAP = 1'b0,
        CNT_MODE_SAT  = 1'b1
    } cnt_mode_e;

    function automatic bit modulus_ok(int width, longint modulus);
        return (width >= 1) && (modulus >= 2) &&
               (modulus <= (longint'(1) << width));
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-count and flag calculator for up_down_mod_counter.
// Math is carried in WIDTH+1 bits so a full 2^WIDTH modulus wraps cleanly.
module mod_counter_next
    import up_down_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = `CNT_MODE_WRAP
) (
    input  logic [WIDTH-1:0] count,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] next_count,
    output logic             next_wrap,
    output logic             ovf_event,
    output logic             tc
);

    localparam logic [WIDTH:0] MAX = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH:0] cnt_ext;
    logic [WIDTH:0] lv_ext;
    logic           at_max;
    logic           at_zero;
    logic           cnt_up;
    logic           cnt_dn;

    assign cnt_ext = {1'b0, count};
    assign lv_ext  = {1'b0, load_val};
    assign at_max  = (cnt_ext == MAX);
    assign at_zero = (cnt_ext == '0);
    assign cnt_up  = !load && en && (up == `CNT_DIR_UP);
    assign cnt_dn  = !load && en && (up == `CNT_DIR_DOWN);

    assign tc = !load && en && (up ? at_max : at_zero);

    always_comb begin
        next_count = count;
        next_wrap  = 1'b0;
        ovf_event  = 1'b0;
        unique case (1'b1)
            load: begin
                if (lv_ext > MAX) next_count = WIDTH'(MAX);
                else              next_count = load_val;
            end
            cnt_up: begin
                if (!at_max) begin
                    next_count = WIDTH'(cnt_ext + 1'b1);
                end else begin
                    ovf_event = 1'b1;
                    if (SATURATE == `CNT_MODE_WRAP) begin
                        next_count = '0;
                        next_wrap  = 1'b1;
                    end
                end
            end
            cnt_dn: begin
                if (!at_zero) begin
                    next_count = WIDTH'(cnt_ext - 1'b1);
                end else begin
                    ovf_event = 1'b1;
                    if (SATURATE == `CNT_MODE_WRAP) begin
                        next_count = WIDTH'(MAX);
                        next_wrap  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/up_down_mod_counter.sv
// Parametrised up/down modulo counter with load, saturate mode, tc look-ahead,
// wrap pulse and sticky overflow flag. Only the registers live here.
module up_down_mod_counter
    import up_down_mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = `CNT_MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap,
    output logic             ovf
);

    if (!modulus_ok(WIDTH, longint'(MODULUS))) begin : g_param_chk
        $error("up_down_mod_counter: need WIDTH>=1, 2<=MODULUS<=2^WIDTH");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] next_count;
    logic             next_wrap;
    logic             ovf_event;
    logic             tc_raw;

    mod_counter_next #(
        .WIDTH    (WIDTH),
        .MODULUS  (MODULUS),
        .SATURATE (SATURATE)
    ) u_next (
        .count      (count_q),
        .en         (en),
        .up         (up),
        .load       (load),
        .load_val   (load_val),
        .next_count (next_count),
        .next_wrap  (next_wrap),
        .ovf_event  (ovf_event),
        .tc         (tc_raw)
    );

    // A fresh overflow beats a simultaneous clear.
    always_comb begin
        count_d = next_count;
        wrap_d  = next_wrap;
        ovf_d   = ovf_event | (ovf_q & ~clr_ovf);
        if (!rst_n) begin
            count_d = '0;
            wrap_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
        wrap_q  <= wrap_d;
        ovf_q   <= ovf_d;
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign ovf   = ovf_q;
    assign tc    = tc_raw & rst_n;

endmodule

// File: doc/up_down_mod_counter.md
# up_down_mod_counter

Parametrised up/down modulo counter: the next generation of the team's 4-bit enable counter. It adds configurable width and modulus, direction control, synchronous load, wrap/saturate mode, a terminal-count look-ahead, a one-cycle wrap pulse and a sticky overflow flag. It serves as the general-purpose event/timer counter for datapath and control blocks.

## Interface
- WIDTH, 4, counter width in bits; must be at least 1.
- MODULUS, 16, count range is 0..MODULUS-1; legal range is 2 ≤ MODULUS ≤ 2^WIDTH.
- SATURATE, 0, 0 = wrap at the range ends, 1 = hold at the range ends.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- en  in  1  count enable.
- up  in  1  direction; 1 = increment, 0 = decrement; sampled only when en=1.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- clr_ovf  in  1  clears the sticky overflow flag.
- count  out  WIDTH  current count; registered.
- tc  out  1  terminal count look-ahead; combinational from count, en and up.
- wrap  out  1  one-cycle registered pulse marking a wrap.
- ovf  out  1  sticky flag for overflow or underflow; registered.

## Operation
- Reset (rst_n=0 at a clock edge): count=0, wrap=0, ovf=0. Reset overrides every other input.
- Priority each edge is rst_n, then load, then en. With none of them active, count holds.
- Load: count ← load_val. If load_val ≥ MODULUS, count ← MODULUS-1 (clamped).
  - A load never sets wrap or ovf.
  - A load ignores en and up.
- Count up (en=1, up=1, no load):
  - If count < MODULUS-1: count+1.
  - At MODULUS-1 with SATURATE=0: count ← 0, wrap ← 1, ovf ← 1.
  - At MODULUS-1 with SATURATE=1: count holds, wrap stays 0, ovf ← 1.
- Count down (en=1, up=0, no load):
  - If count > 0: count-1.
  - At 0 with SATURATE=0: count ← MODULUS-1, wrap ← 1, ovf ← 1.
  - At 0 with SATURATE=1: count holds at 0, ovf ← 1.
- wrap is cleared on every edge where no wrap occurs, so it is never high for two consecutive cycles unless two wraps happen back to back.
- ovf stays set until clr_ovf=1 or reset. If clr_ovf=1 on the same edge as a new overflow, ovf remains 1 (set wins).
- tc = en & (up ? count==MODULUS-1 : count==0). tc is forced to 0 while load=1 or rst_n=0.
- Arithmetic:
  - Next-count math uses WIDTH+1 bits internally, so MODULUS = 2^WIDTH wraps without relying on natural rollover.
  - count never leaves the range 0..MODULUS-1.
- Direction may change on any cycle; no dead cycle is required.
- A reset asserted mid-count takes effect at the next edge regardless of load or en.

## Timing
- Latency: inputs sampled at edge N are reflected in count, wrap and ovf after edge N.
- No intra-assignment delays in the RTL.
- tc is valid in the same cycle as the count and inputs that produce it, so it can be used as a look-ahead for the edge that wraps or saturates.
- wrap is high in the cycle where count shows the post-wrap value (0 going up, MODULUS-1 going down).
- Single clock domain. en, up, load, load_val and clr_ovf are synchronous to clk; no input synchronisers.

## Structure
- Shared header counter_defs.vh contains:
  - `define constants for the mode encoding (CNT_MODE_WRAP=0, CNT_MODE_SAT=1).
  - The direction encoding (CNT_DIR_UP=1, CNT_DIR_DOWN=0).
- An elaboration-time parameter check rejects MODULUS < 2 or MODULUS > 2^WIDTH.
- One sub-module, mod_counter_next: a combinational next-state/flag calculator taking count, en, up, load, load_val and producing next_count, next_wrap, ovf_event, tc. The top level holds only the registers.

## Test plan
- Reset, then count up (WIDTH=4, MODULUS=10, SATURATE=0): hold rst_n=0 for 2 edges with en=1, then release and run 12 edges with en=1, up=1.
  - count=0 throughout reset.
  - count sequence 1..9, 0, 1, 2.
  - tc=1 while count=9; wrap=1 only in the cycle count=0.
  - ovf=1 from then on.
- Count down with wrap: load 0, then en=1, up=0 for 2 edges.
  - count 0 → 9 → 8.
  - wrap pulses once; ovf set.
- Saturate mode (SATURATE=1, MODULUS=10):
  - Up at 9 for 3 edges: count stays 9, wrap stays 0, ovf=1.
  - Down from 0: count stays 0.
- Load priority and clamp:
  - load=1, load_val=4'hC, en=1 at the same edge: count=9, wrap=0, ovf unchanged.
  - Next cycle load_val=3: count=3.
- ovf set/clear collision: count=9, en=1, up=1, clr_ovf=1 on the same edge.
  - ovf=1 after that edge.
  - With en=0, clr_ovf=1: ovf=0.
- Full-range modulus and mid-operation reset (WIDTH=4, MODULUS=16):
  - Count 15 → 0 with wrap=1.
  - rst_n=0 together with load=1, load_val=5: count=0, wrap=0, ovf=0.
